// File: rtl/seg7_scan_controller.sv
`default_nettype none
// ============================================================================
// Module  : seg7_scan_controller
// Brief   : Time-shares one external nibble-to-7-segment decoder across
//           DIGITS displays, latching each result into a static segment bank.
// Rev     : 1.0
// ============================================================================
module seg7_scan_controller #(
   parameter int DIGITS        = 4,
   parameter int PRESCALE      = 50000,
   parameter bit BLANK_LEADING = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   value,
   output logic [3:0]            dcd_bin,
   input  logic [6:0]            dcd_seg,
   output logic [7*DIGITS-1:0]   seg_bank,
   output logic                  pending,
   output logic                  frame_done
);

   localparam int c_iw = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int c_cw = $clog2(PRESCALE);
   localparam logic [c_cw-1:0] c_slot_last = c_cw'(PRESCALE - 1);
   localparam logic [c_cw-1:0] c_slot_pre  = c_cw'(PRESCALE - 2);
   localparam logic [c_iw-1:0] c_idx_last  = c_iw'(DIGITS - 1);

   if (DIGITS < 2 || DIGITS > 8 || PRESCALE < 3) begin : g_param_check
      $error("seg7_scan_controller: DIGITS must be 2..8 and PRESCALE >= 3");
   end

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_PRESENT = 2'd1,
      S_CAPTURE = 2'd2,
      S_HOLD    = 2'd3
   } state_t;

   state_t              r_state;
   logic [c_iw-1:0]     r_idx;
   logic [c_cw-1:0]     r_slot;
   logic [4*DIGITS-1:0] r_active;
   logic [4*DIGITS-1:0] r_shadow;
   logic                r_pending;
   logic [3:0]          r_dcd;
   logic                r_frame_done;
   logic [6:0]          r_seg [DIGITS];

   logic [3:0]          w_act_nib [DIGITS];
   logic [DIGITS-1:0]   w_blank;
   logic [4*DIGITS-1:0] w_frame_active;
   logic [c_iw-1:0]     w_idx_inc;
   logic                w_last_digit;
   logic                w_slot_end;
   logic                w_frame_start;

   for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      assign w_act_nib[i]       = r_active[4*i +: 4];
      assign seg_bank[7*i +: 7] = r_seg[i];
   end

   // A digit is blank when it and every more-significant nibble are zero.
   always_comb begin
      w_blank = '0;
      for (int i = 1; i < DIGITS; i++) begin
         w_blank[i] = BLANK_LEADING && ((r_active >> (4*i)) == '0);
      end
   end

   assign w_frame_active = r_pending ? r_shadow : r_active;
   assign w_idx_inc      = r_idx + 1'b1;
   assign w_last_digit   = (r_idx == c_idx_last);
   assign w_slot_end     = (r_state == S_HOLD) && (r_slot == c_slot_last);
   assign w_frame_start  = enable && ((r_state == S_IDLE) || (w_slot_end && w_last_digit));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_idx        <= '0;
         r_slot       <= '0;
         r_active     <= '0;
         r_shadow     <= '0;
         r_pending    <= 1'b0;
         r_dcd        <= 4'h0;
         r_frame_done <= 1'b0;
         for (int i = 0; i < DIGITS; i++) begin
            r_seg[i] <= 7'h7F;
         end
      end else begin
         r_frame_done <= ((r_state == S_CAPTURE) || (r_state == S_HOLD)) &&
                         (r_slot == c_slot_pre) && w_last_digit;

         // Load is ordered after the transfer so a coincident load stays pending.
         if (w_frame_start) begin
            r_active  <= w_frame_active;
            r_pending <= 1'b0;
         end
         if (load) begin
            r_shadow  <= value;
            r_pending <= 1'b1;
         end

         case (r_state)
            S_IDLE: begin
               if (enable) begin
                  r_state <= S_PRESENT;
                  r_idx   <= '0;
                  r_slot  <= '0;
                  r_dcd   <= w_frame_active[3:0];
               end
            end
            S_PRESENT: begin
               r_state <= S_CAPTURE;
               r_slot  <= r_slot + 1'b1;
            end
            S_CAPTURE: begin
               r_seg[r_idx] <= w_blank[r_idx] ? 7'h7F : dcd_seg;
               r_state      <= S_HOLD;
               r_slot       <= r_slot + 1'b1;
            end
            S_HOLD: begin
               if (r_slot == c_slot_last) begin
                  r_slot <= '0;
                  if (!enable) begin
                     r_state <= S_IDLE;
                     r_idx   <= '0;
                  end else if (w_last_digit) begin
                     r_state <= S_PRESENT;
                     r_idx   <= '0;
                     r_dcd   <= w_frame_active[3:0];
                  end else begin
                     r_state <= S_PRESENT;
                     r_idx   <= w_idx_inc;
                     r_dcd   <= w_act_nib[w_idx_inc];
                  end
               end else begin
                  r_slot <= r_slot + 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign dcd_bin    = r_dcd;
   assign pending    = r_pending;
   assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_controller.sv
`default_nettype none
// ============================================================================
// Module  : tb_seg7_scan_controller
// Brief   : Directed plus randomized bench for seg7_scan_controller with a
//           DE2 decoder model in the loop and a frame-position reference model.
// Rev     : 1.0
// ============================================================================
module tb_seg7_scan_controller;

   localparam int D  = 4;
   localparam int P  = 4;
   localparam bit BL = 1;

   logic        clk    = 1'b0;
   logic        rst    = 1'b1;
   logic        enable = 1'b0;
   logic        load   = 1'b0;
   logic [15:0] value  = 16'h0;
   logic [3:0]  dcd_bin;
   logic [6:0]  dcd_seg;
   logic [27:0] seg_bank;
   logic        pending;
   logic        frame_done;

   int n_total = 0;
   int n_bad   = 0;

   // Reference model: frame position counter rather than an explicit FSM.
   bit          m_busy;
   int          m_pos;
   logic [15:0] m_act;
   logic [15:0] m_sh;
   bit          m_pend;
   logic [3:0]  m_dcd;
   logic [6:0]  m_bank [D];

   always #5 clk = ~clk;

   function automatic logic [6:0] seg7(input logic [3:0] n);
      case (n)
         4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
         4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
         4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
         4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
      endcase
   endfunction

   assign dcd_seg = seg7(dcd_bin);

   seg7_scan_controller #(
      .DIGITS        (D),
      .PRESCALE      (P),
      .BLANK_LEADING (BL)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .load       (load),
      .value      (value),
      .dcd_bin    (dcd_bin),
      .dcd_seg    (dcd_seg),
      .seg_bank   (seg_bank),
      .pending    (pending),
      .frame_done (frame_done)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [3:0] nib(input logic [15:0] v, input int i);
      return v[4*i +: 4];
   endfunction

   function automatic bit blank(input int i);
      return BL && (i != 0) && ((m_act >> (4*i)) == 16'h0);
   endfunction

   task automatic model_reset();
      m_busy = 0; m_pos = 0; m_act = 0; m_sh = 0; m_pend = 0; m_dcd = 0;
      for (int i = 0; i < D; i++) m_bank[i] = 7'h7F;
   endtask

   task automatic model_edge(input bit e, input bit l, input logic [15:0] v);
      bit start = 0;
      int dig, slot;
      if (!m_busy) begin
         if (e) start = 1;
      end else begin
         dig  = m_pos / P;
         slot = m_pos % P;
         if (slot == 1) m_bank[dig] = blank(dig) ? 7'h7F : seg7(nib(m_act, dig));
         if (slot == P-1) begin
            if (!e)             m_busy = 0;
            else if (dig == D-1) start = 1;
            else                m_pos++;
         end else begin
            m_pos++;
         end
      end
      if (start) begin
         m_busy = 1;
         m_pos  = 0;
         if (m_pend) begin
            m_act  = m_sh;
            m_pend = 0;
         end
      end
      if (l) begin
         m_sh   = v;
         m_pend = 1;
      end
      if (m_busy) m_dcd = nib(m_act, m_pos / P);
   endtask

   task automatic check_all();
      logic [27:0] eb;
      for (int i = 0; i < D; i++) eb[7*i +: 7] = m_bank[i];
      check("seg_bank",   seg_bank,   eb);
      check("dcd_bin",    dcd_bin,    m_dcd);
      check("pending",    pending,    m_pend);
      check("frame_done", frame_done, (m_busy && m_pos == D*P-1));
   endtask

   task automatic step(input bit e, input bit l, input logic [15:0] v);
      enable = e; load = l; value = v;
      @(posedge clk);
      if (rst) model_reset();
      else     model_edge(e, l, v);
      #1;
      check_all();
      load = 0;
   endtask

   task automatic run_until(input int target, input string tag);
      int k = 0;
      while (!(m_busy && m_pos == target) && k < 64) begin
         step(1, 0, 16'h0);
         k++;
      end
      check(tag, (m_busy && m_pos == target), 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [15:0] rv;
      bit re, rl;
      model_reset();
      rst = 1;
      repeat (3) step(0, 0, 16'h0);
      check("reset_bank", seg_bank, 28'hFFFFFFF);
      rst = 0;
      repeat (20) step(0, 0, 16'h0);

      // load then scan
      step(0, 1, 16'h1234);
      repeat (40) step(1, 0, 16'h0);
      check("bank_1234", seg_bank, {7'h79, 7'h24, 7'h30, 7'h19});

      // mid-frame load, then a load on the frame-start cycle is deferred
      run_until(P, "reach_slot1");
      step(1, 1, 16'h5678);
      run_until(D*P-1, "reach_frame_end");
      step(1, 1, 16'h0102);
      check("defer_pending", pending, 1);
      check("defer_dcd", dcd_bin, 4'h8);
      repeat (40) step(1, 0, 16'h0);
      check("bank_0102", seg_bank, {7'h7F, 7'h79, 7'h40, 7'h24});

      step(1, 1, 16'h0007);
      repeat (40) step(1, 0, 16'h0);
      check("bank_0007", seg_bank, {7'h7F, 7'h7F, 7'h7F, 7'h78});
      step(1, 1, 16'h0000);
      repeat (40) step(1, 0, 16'h0);
      check("bank_0000", seg_bank, {7'h7F, 7'h7F, 7'h7F, 7'h40});

      // enable dropped in slot 2
      step(1, 1, 16'h4321);
      repeat (40) step(1, 0, 16'h0);
      run_until(2*P+1, "reach_slot2");
      repeat (12) step(0, 0, 16'h0);
      step(1, 0, 16'h0);
      check("restart_dcd", dcd_bin, 4'h1);

      // async reset during the digit-3 capture cycle
      run_until(3*P, "reach_slot3");
      step(1, 1, 16'h9ABC);
      #3 rst = 1;
      #1;
      check("async_bank", seg_bank, 28'hFFFFFFF);
      check("async_pend", pending, 0);
      model_reset();
      @(posedge clk); #1;
      check_all();
      rst = 0;
      repeat (5) step(0, 0, 16'h0);

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         re = ($urandom_range(0, 9) != 0);
         rl = ($urandom_range(0, 7) == 0);
         rv = 16'($urandom);
         rv = rv >> (4 * $urandom_range(0, 4));
         step(re, rl, rv);
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/seg7_scan_controller.md
Name: seg7_scan_controller

Overview:
- Sequences one shared 4-bit binary-to-7-segment decoder (combinational, active-low segments, DE2 HEX convention) across DIGITS display positions.
- Each slot: presents one nibble to the decoder, captures the returned segment pattern into a per-digit bank, then idles for the rest of the slot.
- The segment bank drives HEX0..HEX(DIGITS-1) statically.
- Values load through a double-buffered register. Leading zeros can be blanked.

Parameters:
- DIGITS, 4, number of display positions and nibbles; 2..8.
- PRESCALE, 50000, clock cycles per digit slot; must be >= 3. A compile-time check fails otherwise.
- BLANK_LEADING, 1, 1 = blank leading-zero digits; digit 0 is never blanked.

Ports:
- clk  in  1  system clock (CLOCK_50 on DE2).
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  run scanning; level-sensitive.
- load  in  1  one-cycle strobe; captures value into shadow register.
- value  in  4*DIGITS  nibble i = value[4i+3:4i]; nibble 0 maps to HEX0.
- dcd_bin  out  4  nibble to shared decoder; {d,c,b,a} = dcd_bin[3:0].
- dcd_seg  in  7  decoder result {g,f,e,d,c,b,a}, active-low.
- seg_bank  out  7*DIGITS  digit i = seg_bank[7i+6:7i], active-low, to HEXi.
- pending  out  1  shadow holds a value not yet applied.
- frame_done  out  1  one-cycle pulse at end of each complete frame.

Behaviour:
- Reset (async assert, sync release):
  - seg_bank all 1s (every digit 7'h7F, blank); dcd_bin = 0.
  - active and shadow registers = 0; pending = 0; frame_done = 0.
  - idx = 0; slot_cnt = 0; state = IDLE.
- States: IDLE, PRESENT, CAPTURE, HOLD.
  - IDLE: outputs hold. enable = 1 → next cycle PRESENT with idx = 0, slot_cnt = 0 (frame start).
  - PRESENT (slot_cnt = 0): dcd_bin = active nibble idx. Next state is CAPTURE.
  - CAPTURE (slot_cnt = 1): dcd_bin still holds nibble idx. seg_bank digit idx <= blank(idx) ? 7'h7F : dcd_seg; new pattern visible the following cycle. Next state is HOLD.
  - HOLD (slot_cnt 2..PRESCALE-1): dcd_bin holds.
  - At slot_cnt = PRESCALE-1, the slot ends:
    - idx < DIGITS-1: if enable, go to PRESENT with idx+1; else go to IDLE.
    - idx = DIGITS-1: frame_done = 1 that cycle; idx wraps to 0; if enable, go to PRESENT (frame start); else go to IDLE.
- Frame start (entering PRESENT with idx = 0): if pending, active <= shadow and pending <= 0.
- load:
  - Any cycle, any state: shadow <= value; pending <= 1.
  - A load on the same cycle as a frame-start transfer overwrites shadow after the transfer, so pending stays 1 and the new value applies at the next frame.
  - The active value never changes mid-frame.
- Leading-zero blanking (uses the active register): blank(i) = BLANK_LEADING && i != 0 && nibbles DIGITS-1 down to i are all 0.
- Latency:
  - Digit i is updated at cycle i*PRESCALE+1 after frame start and is visible one cycle later.
  - A full frame lasts DIGITS*PRESCALE cycles.
- Deasserting enable mid-slot: the current slot completes, including its capture, then the block goes to IDLE. frame_done is not pulsed unless the slot completes the last digit. Re-enabling restarts from idx 0.
- Async reset mid-operation (including the CAPTURE cycle): the bank blanks immediately and no partial capture survives.

Test Plan:
Use DIGITS=4, PRESCALE=4, BLANK_LEADING=1, with a real decoder model in the loop.
1. Reset: hold rst for 3 cycles → seg_bank = 28'hFFFFFFF, dcd_bin = 0, pending = 0, frame_done = 0. Release with enable = 0 → outputs unchanged for 20 cycles.
2. Load and scan: load value 16'h1234, then enable = 1 → frame start applies the value, pending clears, dcd_bin = 4,3,2,1 at frame cycles 0,4,8,12.
   - Digits 0..3 = 0x19, 0x30, 0x24, 0x79.
   - frame_done pulses once at frame cycle 15 and again every 16 cycles.
3. Blanking, value 16'h0007 → digit0 = 0x78, digits 1..3 = 0x7F.
   - value 16'h0000 → digit0 = 0x40, others 0x7F.
   - value 16'h0102 → digit0 = 0x24, digit1 = 0x40, digit2 = 0x79, digit3 = 0x7F.
4. Mid-frame load: during slot 1 of a frame showing 16'h1234, load 16'h5678 → pending = 1; slots 1..3 still present 3,2,1.
   - At next frame start, pending = 0 and dcd_bin = 8.
   - A second load on the frame-start cycle leaves pending = 1 with that value deferred one frame.
5. Enable drop: deassert enable at slot 2, cycle 1 → slot 2 captures digit2, state IDLE after cycle 11.
   - No frame_done; bank holds.
   - Re-enable → scan restarts at dcd_bin = nibble 0.
6. Async reset: assert rst in the CAPTURE cycle of digit 3 → seg_bank all 1s within the same cycle; no capture after release; pending cleared.
